// File: rtl/vga_sync_decoder.sv
// Recovers VGA pixel/line position and timing lock from raw hsync/vsync.
// Optional input synchronizer: define VGA_SYNC_DECODER_CDC_EN.
module vga_sync_decoder #(
   parameter int H_DISPLAY = 640,
   parameter int H_BACK    = 48,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int V_DISPLAY = 480,
   parameter int V_TOP     = 33,
   parameter int V_BOTTOM  = 10,
   parameter int V_SYNC    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [9:0]  hpos,
   output logic [9:0]  vpos,
   output logic        display_on,
   output logic        frame_start,
   output logic        locked,
   output logic [10:0] line_len,
   output logic [9:0]  frame_lines,
   output logic [7:0]  err_cnt
);

   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
   localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
   localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

   localparam logic [9:0]  H_SYNC_START_C = 10'(H_SYNC_START);
   localparam logic [9:0]  H_MAX_C        = 10'(H_MAX);
   localparam logic [9:0]  V_SYNC_START_C = 10'(V_SYNC_START);
   localparam logic [9:0]  V_MAX_C        = 10'(V_MAX);
   localparam logic [9:0]  H_DISPLAY_C    = 10'(H_DISPLAY);
   localparam logic [9:0]  V_DISPLAY_C    = 10'(V_DISPLAY);
   localparam logic [10:0] H_TOTAL_C      = 11'(H_MAX + 1);
   localparam logic [9:0]  V_TOTAL_C      = 10'(V_MAX + 1);
   localparam logic [10:0] H_TIMEOUT_C    = 11'(2 * (H_MAX + 1));

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        hs_q, vs_q, vs_rise_q, vs_rise_d;
   logic [9:0]  hpos_q, hpos_d, vpos_q, vpos_d;
   logic [10:0] hcnt_q, hcnt_d, line_len_q, line_len_d;
   logic [9:0]  line_cnt_q, line_cnt_d, frame_lines_q, frame_lines_d;
   logic [7:0]  err_q, err_d;
   logic [1:0]  good_q, good_d;
   logic        line_seen_q, line_seen_d, frame_seen_q, frame_seen_d;
   logic        hs_src, vs_src;
   logic        rise_s, onset_s, line_meas_s, line_bad_s;
   logic        frame_meas_s, frame_bad_s, timeout_s, search_entry_s;
   logic [9:0]  frame_count_s;

`ifdef VGA_SYNC_DECODER_CDC_EN
   logic hs_m_q, hs_s_q, vs_m_q, vs_s_q;

   // Two-flop synchronizer for asynchronous sync inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_m_q <= 1'b0;
         hs_s_q <= 1'b0;
         vs_m_q <= 1'b0;
         vs_s_q <= 1'b0;
      end else begin
         hs_m_q <= hsync_in;
         hs_s_q <= hs_m_q;
         vs_m_q <= vsync_in;
         vs_s_q <= vs_m_q;
      end
   end

   assign hs_src = hs_s_q;
   assign vs_src = vs_s_q;
`else
   assign hs_src = hsync_in;
   assign vs_src = vsync_in;
`endif

   assign rise_s        = hs_src & ~hs_q;
   assign onset_s       = rise_s & vs_q & ~vs_rise_q;
   assign line_meas_s   = rise_s & line_seen_q;
   assign line_bad_s    = line_meas_s & (hcnt_q != H_TOTAL_C);
   // The onset rise itself belongs to the frame being closed
   assign frame_count_s = (line_cnt_q == 10'h3FF) ? line_cnt_q : line_cnt_q + 10'd1;
   assign frame_meas_s  = onset_s & frame_seen_q;
   assign frame_bad_s   = frame_meas_s & (frame_count_s != V_TOTAL_C);
   assign timeout_s     = ~rise_s & (hcnt_q >= H_TIMEOUT_C);

   // Next-state logic for counters, measurements and the lock FSM
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = err_q;

      if (rise_s) begin
         hpos_d    = H_SYNC_START_C;
         hcnt_d    = 11'd1;
         vs_rise_d = vs_q;
      end else begin
         hpos_d    = (hpos_q == H_MAX_C) ? 10'd0 : hpos_q + 10'd1;
         hcnt_d    = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
         vs_rise_d = vs_rise_q;
      end

      if (onset_s) begin
         vpos_d     = V_SYNC_START_C;
         line_cnt_d = 10'd0;
      end else if (rise_s) begin
         vpos_d     = (vpos_q == V_MAX_C) ? 10'd0 : vpos_q + 10'd1;
         line_cnt_d = (line_cnt_q == 10'h3FF) ? line_cnt_q : line_cnt_q + 10'd1;
      end else begin
         vpos_d     = vpos_q;
         line_cnt_d = line_cnt_q;
      end

      line_len_d    = line_meas_s  ? hcnt_q        : line_len_q;
      frame_lines_d = frame_meas_s ? frame_count_s : frame_lines_q;

      case (state_q)
         ST_SEARCH: begin
            if (onset_s) begin
               state_d = ST_VERIFY;
               good_d  = 2'd0;
            end else begin
               state_d = ST_SEARCH;
            end
         end
         ST_VERIFY: begin
            if (line_bad_s || frame_bad_s) begin
               state_d = ST_SEARCH;
            end else if (frame_meas_s) begin
               good_d  = good_q + 2'd1;
               state_d = (good_q == 2'd1) ? ST_LOCKED : ST_VERIFY;
            end else begin
               state_d = ST_VERIFY;
            end
         end
         ST_LOCKED: begin
            if (line_bad_s || frame_bad_s || timeout_s) begin
               state_d = ST_SEARCH;
               err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_SEARCH;
         end
      endcase

      // Measurements restart from scratch whenever lock is abandoned
      search_entry_s = (state_d == ST_SEARCH) && (state_q != ST_SEARCH);
      line_seen_d    = search_entry_s ? 1'b0 : (line_seen_q | rise_s);
      frame_seen_d   = search_entry_s ? 1'b0 : (frame_seen_q | onset_s);
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_SEARCH;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         vs_rise_q     <= 1'b0;
         hpos_q        <= 10'd0;
         vpos_q        <= 10'd0;
         hcnt_q        <= 11'd0;
         line_cnt_q    <= 10'd0;
         line_len_q    <= 11'd0;
         frame_lines_q <= 10'd0;
         err_q         <= 8'd0;
         good_q        <= 2'd0;
         line_seen_q   <= 1'b0;
         frame_seen_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_src;
         vs_q          <= vs_src;
         vs_rise_q     <= vs_rise_d;
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         hcnt_q        <= hcnt_d;
         line_cnt_q    <= line_cnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         err_q         <= err_d;
         good_q        <= good_d;
         line_seen_q   <= line_seen_d;
         frame_seen_q  <= frame_seen_d;
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign err_cnt     = err_q;
   assign locked      = (state_q == ST_LOCKED);
   assign display_on  = locked && (hpos_q < H_DISPLAY_C) && (vpos_q < V_DISPLAY_C);
   assign frame_start = locked && (hpos_q == 10'd0) && (vpos_q == 10'd0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench: a small-timing sync generator drives the decoder,
// a table of positions feeds a scoreboard, hand sequences cover lock loss.
module tb_vga_sync_decoder;

   localparam int HD = 16, HB = 4, HF = 2, HSY = 3;
   localparam int VD = 10, VT_ = 3, VB = 2, VSY = 2;
   localparam int HSS = HD + HF;
   localparam int HT  = HD + HB + HF + HSY;
   localparam int VSS = VD + VB;
   localparam int VT  = VD + VT_ + VB + VSY;
`ifdef VGA_SYNC_DECODER_CDC_EN
   localparam int OFS = 4;
`else
   localparam int OFS = 2;
`endif
   localparam int EDGE_H = HSS + OFS;
   localparam int BUDGET = 3000;

   logic        clk, reset, hsync_in, vsync_in;
   logic [9:0]  hpos, vpos, frame_lines;
   logic        display_on, frame_start, locked;
   logic [10:0] line_len;
   logic [7:0]  err_cnt;

   logic gen_rst, hs_kill;
   int   gen_h, gen_v, gen_f, h_tot, v_tot;
   int   n_checks, n_errors;

   typedef struct {
      int         f;
      int         v;
      int         h;
      logic [9:0] e_hpos;
      logic [9:0] e_vpos;
      logic       e_disp;
      logic       e_fs;
   } vec_t;

   vec_t tbl[12];
   vec_t exp_q[$];
   vec_t e;

   vga_sync_decoder #(
      .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HSY),
      .V_DISPLAY(VD), .V_TOP(VT_), .V_BOTTOM(VB), .V_SYNC(VSY)
   ) dut (
      .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hpos(hpos), .vpos(vpos), .display_on(display_on), .frame_start(frame_start),
      .locked(locked), .line_len(line_len), .frame_lines(frame_lines), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference sync generator with registered sync outputs
   always @(posedge clk) begin
      if (gen_rst) begin
         gen_h <= 0; gen_v <= 0; gen_f <= 0;
         hsync_in <= 1'b0; vsync_in <= 1'b0;
      end else begin
         if (gen_h >= h_tot - 1) begin
            gen_h <= 0;
            if (gen_v >= v_tot - 1) begin
               gen_v <= 0;
               gen_f <= gen_f + 1;
            end else begin
               gen_v <= gen_v + 1;
            end
         end else begin
            gen_h <= gen_h + 1;
         end
         hsync_in <= !hs_kill && gen_h >= HSS && gen_h < HSS + HSY;
         vsync_in <= gen_v >= VSS && gen_v < VSS + VSY;
      end
   end

   function automatic vec_t model(input int f, input int v, input int h);
      vec_t r;
      int   eh, ev;
      eh = (h + HT - OFS) % HT;
      ev = (h >= EDGE_H) ? v : (v + VT - 1) % VT;
      r.f = f; r.v = v; r.h = h;
      r.e_hpos = 10'(eh);
      r.e_vpos = 10'(ev);
      r.e_disp = (eh < HD) && (ev < VD);
      r.e_fs   = (eh == 0) && (ev == 0);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (gen f%0d v%0d h%0d)",
                  name, act, exp, gen_f, gen_v, gen_h);
      end
   endtask

   task automatic wait_pos(input int f, input int v, input int h);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(gen_f == f && gen_v == v && gen_h == h) && n < BUDGET);
      if (!(gen_f == f && gen_v == v && gen_h == h)) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_pos: position f%0d v%0d h%0d not reached within %0d cycles", f, v, h, BUDGET);
         $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
         $finish;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " hpos"}, 32'(hpos), 32'd0);
      check({tag, " vpos"}, 32'(vpos), 32'd0);
      check({tag, " line_len"}, 32'(line_len), 32'd0);
      check({tag, " frame_lines"}, 32'(frame_lines), 32'd0);
      check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, " locked"}, 32'(locked), 32'd0);
      check({tag, " display_on"}, 32'(display_on), 32'd0);
      check({tag, " frame_start"}, 32'(frame_start), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      reset = 1'b1; gen_rst = 1'b1; hs_kill = 1'b0;
      h_tot = HT; v_tot = VT;

      tbl[0]  = model(3, 0, 0);   tbl[1]  = model(3, 0, 19);  tbl[2]  = model(3, 0, 20);
      tbl[3]  = model(3, 1, 1);   tbl[4]  = model(3, 1, 2);   tbl[5]  = model(3, 1, 3);
      tbl[6]  = model(3, 5, 17);  tbl[7]  = model(3, 5, 18);  tbl[8]  = model(3, 10, 5);
      tbl[9]  = model(3, 11, 5);  tbl[10] = model(3, 12, 21); tbl[11] = model(3, 16, 24);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0; gen_rst = 1'b0;

      // Lock is reached at the third vsync onset
      wait_pos(2, VSS, EDGE_H - 1);
      check("pre_lock locked", 32'(locked), 32'd0);
      wait_pos(2, VSS, EDGE_H);
      check("lock locked", 32'(locked), 32'd1);
      check("lock line_len", 32'(line_len), 32'(HT));
      check("lock frame_lines", 32'(frame_lines), 32'(VT));
      check("lock err_cnt", 32'(err_cnt), 32'd0);

      foreach (tbl[i]) begin
         wait_pos(tbl[i].f, tbl[i].v, tbl[i].h);
         exp_q.push_back(tbl[i]);
         e = exp_q.pop_front();
         check($sformatf("tbl%0d hpos", i), 32'(hpos), 32'(e.e_hpos));
         check($sformatf("tbl%0d vpos", i), 32'(vpos), 32'(e.e_vpos));
         check($sformatf("tbl%0d display_on", i), 32'(display_on), 32'(e.e_disp));
         check($sformatf("tbl%0d frame_start", i), 32'(frame_start), 32'(e.e_fs));
      end

      // One line stretched by a clock
      wait_pos(4, 3, 0);
      h_tot = HT + 1;
      wait_pos(4, 4, 0);
      h_tot = HT;
      wait_pos(4, 4, EDGE_H - 1);
      check("stretch locked_before", 32'(locked), 32'd1);
      wait_pos(4, 4, EDGE_H);
      check("stretch locked", 32'(locked), 32'd0);
      check("stretch err_cnt", 32'(err_cnt), 32'd1);
      check("stretch line_len", 32'(line_len), 32'(HT + 1));
      wait_pos(6, VSS, EDGE_H);
      check("relock1 locked", 32'(locked), 32'd1);

      // hsync held low until the timeout fires
      wait_pos(7, 2, 0);
      hs_kill = 1'b1;
      wait_pos(7, 3, EDGE_H - 1);
      check("timeout locked_before", 32'(locked), 32'd1);
      wait_pos(7, 3, EDGE_H);
      check("timeout locked", 32'(locked), 32'd0);
      check("timeout err_cnt", 32'(err_cnt), 32'd2);
      wait_pos(7, 4, 0);
      hs_kill = 1'b0;
      wait_pos(9, VSS, EDGE_H);
      check("relock2 locked", 32'(locked), 32'd1);

      // A frame one line short
      wait_pos(9, VSS + 1, 0);
      v_tot = VT - 1;
      wait_pos(10, 1, 0);
      v_tot = VT;
      wait_pos(10, VSS, EDGE_H - 1);
      check("short locked_before", 32'(locked), 32'd1);
      wait_pos(10, VSS, EDGE_H);
      check("short locked", 32'(locked), 32'd0);
      check("short frame_lines", 32'(frame_lines), 32'(VT - 1));
      check("short err_cnt", 32'(err_cnt), 32'd3);
      wait_pos(13, VSS, EDGE_H);
      check("relock3 locked", 32'(locked), 32'd1);

      // Single-cycle reset in the middle of a locked frame
      wait_pos(14, 5, 10);
      reset = 1'b1;
      wait_pos(14, 5, 11);
      reset = 1'b0;
      check_all_zero("midreset");
      wait_pos(16, VSS, EDGE_H - 1);
      check("midreset locked_before", 32'(locked), 32'd0);
      wait_pos(16, VSS, EDGE_H);
      check("midreset relock", 32'(locked), 32'd1);
      check("midreset err_cnt", 32'(err_cnt), 32'd0);
      check("midreset frame_lines", 32'(frame_lines), 32'(VT));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
